// File: rtl/pe_array_sched.sv
// Job scheduler for a row of NUM_PE processing elements: loads groups of windows,
// paces MAC beats against the input stream, then drains one partial sum per PE.
module pe_array_sched #(
    parameter int NUM_PE = 4,
    parameter int SW     = $clog2(NUM_PE)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        kernel_size,
    input  logic [15:0]       num_windows,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NUM_PE-1:0] pe_en,
    output logic              pe_stall,
    output logic [7:0]        pe_kernel_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_sel,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] MAC   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]    state_reg, state_next;
    logic [7:0]    ks_reg, ks_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [15:0]   rem_reg, rem_next;
    logic [SW-1:0] sel_reg, sel_next;
    logic [15:0]   grp;
    logic          beat;
    logic          drain_acc;
    logic          last_drain;

    // Current group size: a full row of PEs, or whatever windows are left.
    assign grp        = (rem_reg >= 16'(NUM_PE)) ? 16'(NUM_PE) : rem_reg;
    assign beat       = (state_reg == MAC) && in_valid;
    assign drain_acc  = (state_reg == DRAIN) && out_ready;
    assign last_drain = drain_acc && (16'(sel_reg) == (grp - 16'd1));

    always_comb begin
        state_next = state_reg;
        ks_next    = ks_reg;
        cnt_next   = cnt_reg;
        rem_next   = rem_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if ((kernel_size != 8'd0) && (num_windows != 16'd0)) begin
                        ks_next    = kernel_size;
                        rem_next   = num_windows;
                        state_next = LOAD;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            LOAD: begin
                cnt_next   = 8'd0;
                sel_next   = '0;
                state_next = MAC;
            end
            MAC: begin
                if (beat) begin
                    if (cnt_reg == (ks_reg - 8'd1)) begin
                        cnt_next   = 8'd0;
                        state_next = DRAIN;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (last_drain) begin
                    rem_next   = rem_reg - grp;
                    sel_next   = '0;
                    state_next = (rem_reg != grp) ? LOAD : FIN;
                end else if (drain_acc) begin
                    sel_next = sel_reg + SW'(1);
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            ks_reg    <= 8'd0;
            cnt_reg   <= 8'd0;
            rem_reg   <= 16'd0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ks_reg    <= ks_next;
            cnt_reg   <= cnt_next;
            rem_reg   <= rem_next;
            sel_reg   <= sel_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe_en
            assign pe_en[gi] = (state_reg == LOAD) && (16'(gi) < grp);
        end
    endgenerate

    assign in_ready       = (state_reg == MAC);
    assign pe_stall       = ((state_reg == MAC) && !in_valid) || (state_reg == DRAIN);
    assign out_valid      = (state_reg == DRAIN);
    assign out_sel        = sel_reg;
    assign pe_kernel_size = ks_reg;
    assign busy           = (state_reg != IDLE);
    assign done           = (state_reg == FIN);

endmodule

// File: tb/tb_pe_array_sched.sv
// Randomized scoreboard bench for pe_array_sched: a job-level model queues the expected
// PE groups, beat counts and drain order; a negedge monitor checks what the DUT presents.
module tb_pe_array_sched;

    localparam int NP  = 4;
    localparam int SWB = $clog2(NP);

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [7:0]     kernel_size = 8'd0;
    logic [15:0]    num_windows = 16'd0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic [NP-1:0]  pe_en;
    logic           pe_stall;
    logic [7:0]     pe_kernel_size;
    logic           out_valid;
    logic [SWB-1:0] out_sel;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    logic [NP-1:0] exp_en_q[$];
    int            exp_beats_q[$];
    int            exp_sel_q[$];

    always #5 clk = ~clk;

    pe_array_sched #(.NUM_PE(NP)) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .kernel_size(kernel_size),
        .num_windows(num_windows),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pe_en(pe_en),
        .pe_stall(pe_stall),
        .pe_kernel_size(pe_kernel_size),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel(out_sel),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level reference: windows split into groups of at most NP, each group
    // takes ks beats and drains its PEs in index order.
    task automatic push_expect(input int ks, input int nw);
        int rem;
        int g;
        logic [NP-1:0] m;
        rem = nw;
        if (ks == 0 || nw == 0) return;
        while (rem > 0) begin
            g = (rem < NP) ? rem : NP;
            m = '0;
            for (int i = 0; i < g; i++) m[i] = 1'b1;
            exp_en_q.push_back(m);
            exp_beats_q.push_back(ks);
            for (int i = 0; i < g; i++) exp_sel_q.push_back(i);
            rem -= g;
        end
    endtask

    logic           prev_ov = 1'b0;
    logic           prev_or = 1'b0;
    logic           prev_done = 1'b0;
    logic [SWB-1:0] prev_sel = '0;
    int             beats = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_ov   = 1'b0;
            prev_or   = 1'b0;
            prev_done = 1'b0;
            beats     = 0;
        end else begin
            if (prev_ov && !prev_or) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_sel", longint'(out_sel), longint'(prev_sel));
            end
            if (in_ready) begin
                chk("mac_stall", longint'(pe_stall), longint'(!in_valid));
                if (in_valid) beats++;
            end
            if (out_valid) begin
                chk("drain_in_ready", longint'(in_ready), 0);
                chk("drain_stall", longint'(pe_stall), 1);
                if (!prev_ov) begin
                    chk("group_expected", longint'(exp_beats_q.size() > 0), 1);
                    if (exp_beats_q.size() > 0) chk("mac_beats", beats, exp_beats_q.pop_front());
                    beats = 0;
                end
                if (out_ready) begin
                    chk("drain_expected", longint'(exp_sel_q.size() > 0), 1);
                    if (exp_sel_q.size() > 0) chk("out_sel", longint'(out_sel), exp_sel_q.pop_front());
                end
            end
            if (pe_en != '0) begin
                chk("pe_en_expected", longint'(exp_en_q.size() > 0), 1);
                if (exp_en_q.size() > 0) chk("pe_en", longint'(pe_en), longint'(exp_en_q.pop_front()));
                beats = 0;
            end
            if (done) begin
                done_seen++;
                chk("done_single", longint'(prev_done), 0);
            end
            if (in_ready || out_valid || (pe_en != '0) || done) chk("busy_active", longint'(busy), 1);
            prev_ov   = out_valid;
            prev_or   = out_ready;
            prev_sel  = out_sel;
            prev_done = done;
        end
    end

    // mode 0: in_valid/out_ready held high; 1: random; 2: in_valid low on MAC
    // cycles 2 and 3 of each group, out_ready toggling. Stray starts while busy.
    task automatic run_job(input int ks, input int nw, input int mode);
        int  busy_cnt = 0;
        int  mac_cyc = 0;
        int  mac_idx = 0;
        int  ready_cyc = 0;
        int  groups = 0;
        int  exp_busy = 1;
        int  rem;
        int  g;
        int  d0;
        bit  got_done = 1'b0;
        bit  tgl = 1'b0;
        rem = (ks == 0) ? 0 : nw;
        while (rem > 0) begin
            g = (rem < NP) ? rem : NP;
            exp_busy += 1 + ks + g;
            groups++;
            rem -= g;
        end
        @(posedge clk); #1;
        kernel_size = 8'(ks);
        num_windows = 16'(nw);
        start = 1'b1;
        push_expect(ks, nw);
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b0;
        kernel_size = 8'($urandom);
        num_windows = 16'($urandom);
        for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
            if (in_ready) begin
                mac_idx++;
                ready_cyc++;
            end else begin
                mac_idx = 0;
            end
            case (mode)
                0: begin
                    in_valid = 1'b1;
                    out_ready = 1'b1;
                end
                1: begin
                    in_valid = ($urandom_range(3) != 0);
                    out_ready = ($urandom_range(2) != 0);
                end
                default: begin
                    in_valid = !(mac_idx == 2 || mac_idx == 3);
                    tgl = !tgl;
                    out_ready = tgl;
                end
            endcase
            start = busy && ($urandom_range(4) == 0);
            if (start) begin
                kernel_size = 8'($urandom);
                num_windows = 16'($urandom);
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (in_ready) mac_cyc++;
            if (done) got_done = 1'b1;
            if (!got_done) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("job_done", longint'(got_done), 1);
        @(posedge clk); #1;
        chk("idle_after_fin", longint'(busy), 0);
        chk("done_count", done_seen - d0, 1);
        if (ks != 0 && nw != 0) chk("pe_kernel_size", longint'(pe_kernel_size), ks);
        else chk("no_mac_on_empty", mac_cyc, 0);
        if (mode == 0) chk("busy_cycles", busy_cnt, exp_busy);
        if (mode == 2) chk("mac_cycles", mac_cyc, groups * (ks + 2));
        $display("job ks=%0d nw=%0d mode=%0d busy_cycles=%0d mac_cycles=%0d", ks, nw, mode, busy_cnt, mac_cyc);
    endtask

    initial begin
        int d0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_pe_en", longint'(pe_en), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_pe_stall", longint'(pe_stall), 0);
        chk("rst_ks", longint'(pe_kernel_size), 0);
        @(negedge clk);
        rstn = 1'b1;

        run_job(3, 4, 0);
        run_job(2, 6, 0);
        run_job(4, 3, 2);
        run_job(4, 7, 2);
        run_job(0, 5, 0);
        run_job(3, 0, 0);
        run_job(1, 1, 0);
        run_job(1, 9, 0);
        run_job(255, 1, 0);
        run_job(2, 301, 0);
        for (int j = 0; j < 15; j++) begin
            run_job(int'($urandom_range(6, 1)), int'($urandom_range(20, 1)), 1);
        end

        // Abandon a job in the middle of MAC with an asynchronous reset.
        @(posedge clk); #1;
        kernel_size = 8'd5;
        num_windows = 16'd8;
        start = 1'b1;
        push_expect(5, 8);
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("reached_mac", longint'(in_ready), 1);
        rstn = 1'b0;
        #1;
        chk("arst_busy", longint'(busy), 0);
        chk("arst_in_ready", longint'(in_ready), 0);
        chk("arst_pe_stall", longint'(pe_stall), 0);
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_out_sel", longint'(out_sel), 0);
        chk("arst_pe_en", longint'(pe_en), 0);
        chk("arst_ks", longint'(pe_kernel_size), 0);
        chk("arst_done", longint'(done), 0);
        exp_en_q.delete();
        exp_beats_q.delete();
        exp_sel_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_seen - d0, 0);
        chk("idle_after_reset", longint'(busy), 0);
        run_job(1, 1, 0);

        chk("pe_en_queue_empty", exp_en_q.size(), 0);
        chk("beats_queue_empty", exp_beats_q.size(), 0);
        chk("drain_queue_empty", exp_sel_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
